ahb_master_req_ctrl: RTL
========================

Name: ahb_master_req_ctrl

Overview:
Master-side AHB requester that sits between a local command source and one master port of the interconnect, opposite the per-slave arbiter. It accepts one burst command, raises hreq, waits for hgrant, then drives address/control for every beat (NONSEQ/SEQ) with INCR/WRAP address generation. It moves write/read data through the pipelined data phase, honours slave wait states, and releases the bus after the last beat.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be 8/16/32/64
HSIZE_V, $clog2(DATA_W/8), fixed hsize driven on every beat

Ports:
hclk  in  1  clock
hreset_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_W  start address, aligned to HSIZE_V
cmd_burst  in  3  AHB encoding: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
cmd_write  in  1  1=write, 0=read
hreq  out  1  bus request to arbiter
hgrant  in  1  grant from arbiter; already qualified with ~hwait
hwait  in  1  slave wait (active-high, i.e. ~HREADY)
hresp  in  1  1=ERROR
haddr  out  ADDR_W  address phase
htrans  out  2  IDLE=0, NONSEQ=2, SEQ=3
hburst  out  3  latched cmd_burst
hwrite  out  1  latched cmd_write
hsize  out  3  HSIZE_V
hwdata  out  DATA_W  write data phase
hrdata  in  DATA_W  read data
wdata  in  DATA_W  local write data for the current data phase
wdata_ack  out  1  pulse: wdata consumed
rdata  out  DATA_W  captured read data
rdata_valid  out  1  pulse: rdata valid
done  out  1  one-cycle pulse at burst end
err  out  1  qualifies done; 1 if burst aborted by ERROR

Behaviour:
- Reset (sampled at posedge hclk with hreset_n=0): state IDLE; hreq=0, htrans=IDLE, haddr=0, hburst=0, hwrite=0, hwdata=0, rdata=0, wdata_ack=0, rdata_valid=0, done=0, err=0. Reset mid-burst abandons the burst the same edge; no done.
- Beat count N: SINGLE and INCR=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16. 4-bit beat counter, terminal value N-1.
- States: IDLE, REQ, ADDR, TAIL.
- IDLE: cmd_ready=1. cmd_valid -> latch addr/burst/write, hreq=1 next cycle, go REQ.
- REQ: hreq=1, htrans=IDLE. hgrant=1 -> ADDR next cycle, beat counter=0.
- ADDR: beat 0 drives NONSEQ, later beats SEQ. An address beat is accepted on any cycle with hwait=0; haddr/htrans hold while hwait=1.
  - On acceptance: next address = INCR: addr + (1<<HSIZE_V). WRAP: low bits inside the N*(1<<HSIZE_V) boundary increment modulo the boundary; upper bits are held.
  - Acceptance of beat N-1 goes to TAIL. hreq drops in the cycle after that acceptance.
- Data phase of each beat occupies the cycle after address acceptance and extends while hwait=1.
  - Write: hwdata = wdata registered at address acceptance; wdata_ack pulses in the acceptance cycle.
  - Read: when the data phase completes (hwait=0), rdata<=hrdata and rdata_valid pulses.
- TAIL: htrans=IDLE, hreq=0. When the final data phase completes: done=1, err=0, go IDLE.
- ERROR: hresp=1 with hwait=0 in any data phase ->
  - next cycle htrans=IDLE, hreq=0;
  - no further address beats or data captures;
  - done=1, err=1; go IDLE.
- Simultaneous events: acceptance of the last address and completion of the previous data phase in the same cycle are handled independently. cmd_valid outside IDLE is ignored.

Test Plan:
- INCR4 write at 0x100, hgrant 2 cycles after hreq, no waits -> haddr 0x100/104/108/10C with NONSEQ,SEQ,SEQ,SEQ; 4 wdata_ack pulses; hreq low after 4th acceptance; done=1, err=0 one cycle after the last data phase.
- WRAP8 read at 0x38 (DATA_W=32) -> haddr 0x38,3C,20,24,28,2C,30,34; 8 rdata_valid pulses carrying hrdata in order.
- INCR8 read with hwait=1 for 3 cycles on beat 2 -> haddr/htrans held 3 cycles; beat count and addresses unchanged otherwise; done after 8 reads.
- SINGLE write, hgrant withheld 10 cycles -> hreq held 10 cycles with htrans=IDLE; one NONSEQ beat; done.
- INCR16 read, hresp=1 with hwait=0 on beat 5 data phase -> htrans=IDLE next cycle, hreq=0, done=1 with err=1, no further rdata_valid.
- hreset_n=0 during beat 3 of WRAP4 -> next edge all outputs at reset values, no done; a following cmd is accepted normally.

Source files
------------

// File: rtl/ahb_master_req_ctrl.sv
// ahb_master_req_ctrl
//
// Master-side AHB requester. Takes one burst command from a local source,
// requests the bus, and once granted drives the address/control for every
// beat (NONSEQ then SEQ) with INCR or WRAP address generation. It moves
// write and read data through the pipelined data phase, honours slave wait
// states, and releases the bus after the last beat or on an ERROR response.
//
// Ports:
//   hclk, hreset_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only when idle)
//   cmd_addr/burst/write    burst start address, AHB burst type, direction
//   hreq/hgrant             bus request to / grant from the arbiter
//   hwait/hresp             slave wait (~HREADY) and ERROR response
//   haddr/htrans/hburst/
//   hwrite/hsize            address-phase outputs
//   hwdata/hrdata           data-phase buses
//   wdata/wdata_ack         local write data, consumed on address acceptance
//   rdata/rdata_valid       captured read data with its valid pulse
//   done/err                end-of-burst pulse, err qualifies an aborted burst

module ahb_master_req_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int HSIZE_V = $clog2(DATA_W / 8)
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic              cmd_write,
    output logic              hreq,
    input  logic              hgrant,
    input  logic              hwait,
    input  logic              hresp,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(1) << HSIZE_V;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_TAIL
    } state_t;

    state_t            state;
    logic [3:0]        beat_cnt;
    logic [3:0]        last_beat;
    logic              dphase;
    logic              wrap_burst;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              dphase_done;
    logic              bus_error;
    logic              addr_accept;

    // Terminal beat index for the latched burst; INCR (undefined length) is
    // treated as a single beat.
    always_comb begin
        last_beat = 4'd0;
        case (hburst)
            3'd2, 3'd3: last_beat = 4'd3;
            3'd4, 3'd5: last_beat = 4'd7;
            3'd6, 3'd7: last_beat = 4'd15;
            default:    last_beat = 4'd0;
        endcase
    end

    // WRAP bursts keep the address bits above the N*beat-size boundary and
    // let the bits below it roll over.
    assign wrap_burst = (hburst == 3'd2) || (hburst == 3'd4) || (hburst == 3'd6);
    assign wrap_mask  = ((ADDR_W'({1'b0, last_beat}) + ADDR_W'(1)) << HSIZE_V) - ADDR_W'(1);
    assign incr_addr  = haddr + BEAT_BYTES;
    assign next_addr  = wrap_burst ? ((haddr & ~wrap_mask) | (incr_addr & wrap_mask))
                                   : incr_addr;

    // A data phase ends on the first cycle without a wait; an ERROR on that
    // cycle kills the burst, so the address presented alongside it is not
    // taken and its write data is not consumed.
    assign dphase_done = dphase && !hwait;
    assign bus_error   = dphase_done && hresp;
    assign addr_accept = (state == S_ADDR) && !hwait && !bus_error;

    assign cmd_ready = (state == S_IDLE);
    assign wdata_ack = addr_accept && hwrite;
    assign hsize     = 3'(HSIZE_V);

    // Main sequencer. Address phase and data phase are tracked separately
    // (state vs. dphase) so the last address acceptance and the previous
    // beat's data completion can land in the same cycle.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state       <= S_IDLE;
            beat_cnt    <= 4'd0;
            dphase      <= 1'b0;
            hreq        <= 1'b0;
            htrans      <= TRANS_IDLE;
            haddr       <= '0;
            hburst      <= 3'd0;
            hwrite      <= 1'b0;
            hwdata      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;

            if (dphase_done && !hresp && !hwrite) begin
                rdata       <= hrdata;
                rdata_valid <= 1'b1;
            end

            if (!hwait) begin
                dphase <= addr_accept;
            end

            if (addr_accept && hwrite) begin
                hwdata <= wdata;
            end

            if (bus_error) begin
                state  <= S_IDLE;
                hreq   <= 1'b0;
                htrans <= TRANS_IDLE;
                done   <= 1'b1;
                err    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            haddr  <= cmd_addr;
                            hburst <= cmd_burst;
                            hwrite <= cmd_write;
                            hreq   <= 1'b1;
                            state  <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (hgrant) begin
                            beat_cnt <= 4'd0;
                            htrans   <= TRANS_NONSEQ;
                            state    <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (addr_accept) begin
                            if (beat_cnt == last_beat) begin
                                htrans <= TRANS_IDLE;
                                hreq   <= 1'b0;
                                state  <= S_TAIL;
                            end else begin
                                beat_cnt <= beat_cnt + 4'd1;
                                haddr    <= next_addr;
                                htrans   <= TRANS_SEQ;
                            end
                        end
                    end
                    S_TAIL: begin
                        if (dphase_done) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
